// File: rtl/pr_dma_pkg.sv
// Shared constants, state encoding and bus beat type for the processor-bus DMA master.
package pr_dma_pkg;

   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // CTRL write bits
   localparam int unsigned CTRL_START    = 0;
   localparam int unsigned CTRL_IE       = 1;
   localparam int unsigned CTRL_ABORT    = 2;
   localparam int unsigned CTRL_DONE_CLR = 3;
   // CTRL read bits
   localparam int unsigned CTRL_BUSY     = 0;
   localparam int unsigned CTRL_DONE     = 3;

   localparam logic [3:0]  PR_MASK_WORD  = 4'hF;
   localparam logic [31:0] ADDR_STEP     = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } dmaState_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wData;
      logic [3:0]  mask;
      logic        write;
   } prBeat_t;

endpackage

// File: rtl/pr_dma_regs.sv
// Config register file: SRC/DST/LEN, IE/DONE flags, start/abort decode and read mux.
module pr_dma_regs
   import pr_dma_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [1:0]       CfgAddr,
   input  logic [31:0]      CfgWData,
   input  logic             CfgWEn,
   output logic [31:0]      CfgRData,
   input  logic             busy,
   input  logic             xferDone,
   output logic [31:0]      srcAddr,
   output logic [31:0]      dstAddr,
   output logic [LEN_W-1:0] len,
   output logic             startGo_c,
   output logic             abort_c,
   output logic             ie,
   output logic             done
);

   logic [29:0] srcHi;
   logic [29:0] dstHi;
   logic        ctrlWr;
   logic        startReq;
   logic        doneSet;

   assign ctrlWr    = CfgWEn && (CfgAddr == REG_CTRL);
   assign abort_c   = ctrlWr && CfgWData[CTRL_ABORT];
   // ABORT wins over START; START is ignored while a copy is running
   assign startReq  = ctrlWr && CfgWData[CTRL_START] && !CfgWData[CTRL_ABORT] && !busy;
   assign startGo_c = startReq && (len != '0);
   assign doneSet   = xferDone || (startReq && (len == '0));

   assign srcAddr = {srcHi, 2'b00};
   assign dstAddr = {dstHi, 2'b00};

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         srcHi <= '0;
         dstHi <= '0;
         len   <= '0;
         ie    <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (CfgWEn && !busy) begin
            case (CfgAddr)
               REG_SRC: srcHi <= CfgWData[31:2];
               REG_DST: dstHi <= CfgWData[31:2];
               REG_LEN: len   <= CfgWData[LEN_W-1:0];
               default: ;
            endcase
         end
         if (ctrlWr) ie <= CfgWData[CTRL_IE];
         // a completion on the same edge as DONE_CLR keeps DONE set
         if (doneSet) done <= 1'b1;
         else if (ctrlWr && CfgWData[CTRL_DONE_CLR]) done <= 1'b0;
      end
   end

   always_comb begin
      CfgRData = '0;
      case (CfgAddr)
         REG_SRC: CfgRData = srcAddr;
         REG_DST: CfgRData = dstAddr;
         REG_LEN: CfgRData = 32'(len);
         default: begin
            CfgRData[CTRL_BUSY] = busy;
            CfgRData[CTRL_IE]   = ie;
            CfgRData[CTRL_DONE] = done;
         end
      endcase
   end

endmodule

// File: rtl/pr_dma_master.sv
// Processor-bus DMA initiator: copies LEN words SRC->DST through the bridge, one read and one write per word.
module pr_dma_master
   import pr_dma_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [1:0]  CfgAddr,
   input  logic [31:0] CfgWData,
   input  logic        CfgWEn,
   output logic [31:0] CfgRData,
   output logic        PrReq,
   input  logic        Gnt,
   output logic [31:0] PrAddr,
   output logic [31:0] PrWData,
   output logic [3:0]  PrMask,
   output logic        PrWrite,
   input  logic [31:0] PrRData,
   output logic        IRQ
);

   dmaState_e        state;
   dmaState_e        stateNext;
   logic [31:0]      curSrc;
   logic [31:0]      curDst;
   logic [LEN_W-1:0] cnt;
   logic [31:0]      rdBuf;
   logic [31:0]      srcAddr;
   logic [31:0]      dstAddr;
   logic [LEN_W-1:0] len;
   logic             startGo_c;
   logic             abort_c;
   logic             ie;
   logic             done;
   logic             busy;
   logic             lastBeat;
   logic             xferDone;
   prBeat_t          beat;

   assign busy     = (state != ST_IDLE);
   assign lastBeat = (state == ST_WRITE) && Gnt && (cnt == LEN_W'(1));
   assign xferDone = lastBeat && !abort_c;
   assign IRQ      = done && ie;

   pr_dma_regs #(.LEN_W(LEN_W)) uRegs (
      .Clk       (Clk),
      .Rst       (Rst),
      .CfgAddr   (CfgAddr),
      .CfgWData  (CfgWData),
      .CfgWEn    (CfgWEn),
      .CfgRData  (CfgRData),
      .busy      (busy),
      .xferDone  (xferDone),
      .srcAddr   (srcAddr),
      .dstAddr   (dstAddr),
      .len       (len),
      .startGo_c (startGo_c),
      .abort_c   (abort_c),
      .ie        (ie),
      .done      (done)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:  if (startGo_c) stateNext = ST_READ;
         ST_READ: begin
            if (abort_c)  stateNext = ST_IDLE;
            else if (Gnt) stateNext = ST_WRITE;
         end
         ST_WRITE: begin
            if (abort_c)  stateNext = ST_IDLE;
            else if (Gnt) stateNext = lastBeat ? ST_IDLE : ST_READ;
         end
         default:  stateNext = ST_IDLE;
      endcase
   end

   // working copies; SRC/DST/LEN registers stay untouched so START can rerun the copy
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         curSrc <= '0;
         curDst <= '0;
         cnt    <= '0;
         rdBuf  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (startGo_c) begin
                  curSrc <= srcAddr;
                  curDst <= dstAddr;
                  cnt    <= len;
               end
            end
            ST_READ:  if (Gnt) rdBuf <= PrRData;
            ST_WRITE: begin
               if (Gnt) begin
                  curSrc <= curSrc + ADDR_STEP;
                  curDst <= curDst + ADDR_STEP;
                  cnt    <= cnt - LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // nothing reaches the bus without a grant
   always_comb begin
      beat  = '0;
      PrReq = 1'b0;
      case (state)
         ST_READ: begin
            PrReq = 1'b1;
            if (Gnt) beat.addr = curSrc;
         end
         ST_WRITE: begin
            PrReq = 1'b1;
            if (Gnt) begin
               beat.addr  = curDst;
               beat.wData = rdBuf;
               beat.mask  = PR_MASK_WORD;
               beat.write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign PrAddr  = beat.addr;
   assign PrWData = beat.wData;
   assign PrMask  = beat.mask;
   assign PrWrite = beat.write;

endmodule

// File: tb/tb_pr_dma_master.sv
// Bench for pr_dma_master: register vector table, directed copy scenarios and random copies vs a word-copy model.
module tb_pr_dma_master;
   import pr_dma_pkg::*;

   logic        Clk;
   logic        Rst;
   logic [1:0]  CfgAddr;
   logic [31:0] CfgWData;
   logic        CfgWEn;
   logic [31:0] CfgRData;
   logic        PrReq;
   logic        Gnt;
   logic [31:0] PrAddr;
   logic [31:0] PrWData;
   logic [3:0]  PrMask;
   logic        PrWrite;
   logic [31:0] PrRData;
   logic        IRQ;

   int total = 0;
   int bad   = 0;

   // bridge memory: 256 words selected by address bits [9:2]
   logic [31:0] mem    [256];
   logic [31:0] expMem [256];

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } tx_t;
   tx_t txQ[$];
   tx_t expQ[$];

   typedef struct {
      logic        wen;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRd;
      logic        expIrq;
   } vec_t;
   vec_t vecs[17];

   pr_dma_master #(.LEN_W(16)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .CfgAddr  (CfgAddr),
      .CfgWData (CfgWData),
      .CfgWEn   (CfgWEn),
      .CfgRData (CfgRData),
      .PrReq    (PrReq),
      .Gnt      (Gnt),
      .PrAddr   (PrAddr),
      .PrWData  (PrWData),
      .PrMask   (PrMask),
      .PrWrite  (PrWrite),
      .PrRData  (PrRData),
      .IRQ      (IRQ)
   );

   assign PrRData = mem[PrAddr[9:2]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
      @(negedge Clk);
      CfgAddr  = a;
      CfgWData = d;
      CfgWEn   = 1'b1;
      @(posedge Clk);
      #1;
      CfgWEn = 1'b0;
   endtask

   task automatic cfgRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge Clk);
      CfgAddr = a;
      #1;
      d = CfgRData;
   endtask

   function automatic logic gntAt(input int mode, input int idx);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((idx % 3) == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   // Model: word i is read from src+4i then written to dst+4i, words strictly in order.
   // An abort at busy cycle k (full grant) leaves exactly the first k+1 bus beats.
   task automatic runCopy(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input int mode, input logic ie, input int abortCyc, input int srcWrCyc);
      int          nb;
      int          busyCyc;
      int          lows;
      int          diffs;
      bit          ended;
      logic [31:0] s;
      logic [31:0] d;
      logic [31:0] v;
      logic [31:0] rd;
      cfgWrite(REG_SRC, src);
      cfgWrite(REG_DST, dst);
      cfgWrite(REG_LEN, 32'(n));
      nb = (abortCyc < 0) ? 2 * n : abortCyc + 1;
      expQ.delete();
      txQ.delete();
      for (int b = 0; b < nb; b++) begin
         s = (src & ~32'd3) + 32'(4 * (b / 2));
         d = (dst & ~32'd3) + 32'(4 * (b / 2));
         v = expMem[s[9:2]];
         if ((b % 2) == 0) expQ.push_back('{1'b0, s, v});
         else begin
            expQ.push_back('{1'b1, d, v});
            expMem[d[9:2]] = v;
         end
      end
      cfgWrite(REG_CTRL, 32'h9 | {30'h0, ie, 1'b0});
      busyCyc = 0;
      lows    = 0;
      ended   = 0;
      for (int cyc = 0; cyc < 2 * n + 200; cyc++) begin
         @(negedge Clk);
         Gnt    = gntAt(mode, cyc);
         CfgWEn = 1'b0;
         if (cyc == abortCyc) begin
            CfgWEn = 1'b1; CfgAddr = REG_CTRL; CfgWData = 32'h4 | {30'h0, ie, 1'b0};
         end
         if (cyc == srcWrCyc) begin
            CfgWEn = 1'b1; CfgAddr = REG_SRC; CfgWData = 32'h1234;
         end
         #1;
         if (!PrReq) begin
            ended = 1;
            chk("irqAfterLast", 32'(IRQ), 32'(ie && (abortCyc < 0)));
            break;
         end
         busyCyc++;
         chk("irqWhileBusy", 32'(IRQ), 32'h0);
         if (!Gnt) begin
            lows++;
            chk("noGntCtl", 32'({PrMask, PrWrite}), 32'h0);
            chk("noGntAddr", PrAddr, 32'h0);
            chk("noGntData", PrWData, 32'h0);
         end else begin
            chk("beatMask", 32'(PrMask), PrWrite ? 32'hF : 32'h0);
            txQ.push_back('{PrWrite, PrAddr, PrWrite ? PrWData : PrRData});
            if (PrWrite) mem[PrAddr[9:2]] = PrWData;
         end
      end
      CfgWEn = 1'b0;
      chk("copyEnded", 32'(ended), 32'h1);
      chk("busyCycles", 32'(busyCyc), (abortCyc < 0) ? 32'(2 * n + lows) : 32'(abortCyc + 1));
      chk("beatCount", 32'(txQ.size()), 32'(expQ.size()));
      for (int i = 0; i < txQ.size() && i < expQ.size(); i++) begin
         chk("beatKind", 32'(txQ[i].wr), 32'(expQ[i].wr));
         chk("beatAddr", txQ[i].addr, expQ[i].addr);
         chk("beatData", txQ[i].data, expQ[i].data);
      end
      Gnt = 1'b0;
      cfgRead(REG_CTRL, rd);
      chk("ctrlAfter", rd, ((abortCyc < 0) ? 32'h8 : 32'h0) | {30'h0, ie, 1'b0});
      cfgRead(REG_SRC, rd);
      chk("srcKept", rd, src & ~32'd3);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== expMem[i]) diffs++;
      chk("memImage", 32'(diffs), 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      Rst = 1'b0; Gnt = 1'b0; CfgWEn = 1'b0; CfgAddr = REG_SRC; CfgWData = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = $urandom;
         expMem[i] = mem[i];
      end
      repeat (3) @(posedge Clk);
      #1;
      chk("rstBus", 32'({PrReq, PrMask, PrWrite, IRQ}), 32'h0);
      chk("rstAddr", PrAddr, 32'h0);
      Rst = 1'b1;

      vecs[0]  = '{1'b0, REG_SRC,  32'h0,         32'h0,         1'b0};
      vecs[1]  = '{1'b0, REG_DST,  32'h0,         32'h0,         1'b0};
      vecs[2]  = '{1'b0, REG_LEN,  32'h0,         32'h0,         1'b0};
      vecs[3]  = '{1'b0, REG_CTRL, 32'h0,         32'h0,         1'b0};
      vecs[4]  = '{1'b1, REG_SRC,  32'h1234_5677, 32'h1234_5674, 1'b0};
      vecs[5]  = '{1'b1, REG_DST,  32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
      vecs[6]  = '{1'b1, REG_LEN,  32'hABCD_0000, 32'h0,         1'b0};
      vecs[7]  = '{1'b1, REG_CTRL, 32'h2,         32'h2,         1'b0};
      vecs[8]  = '{1'b1, REG_CTRL, 32'h1,         32'h8,         1'b0};
      vecs[9]  = '{1'b1, REG_CTRL, 32'hA,         32'h2,         1'b0};
      vecs[10] = '{1'b1, REG_CTRL, 32'h3,         32'hA,         1'b1};
      vecs[11] = '{1'b1, REG_CTRL, 32'hB,         32'hA,         1'b1};
      vecs[12] = '{1'b1, REG_CTRL, 32'h8,         32'h0,         1'b0};
      vecs[13] = '{1'b1, REG_CTRL, 32'h5,         32'h0,         1'b0};
      vecs[14] = '{1'b1, REG_LEN,  32'h0001_0005, 32'h5,         1'b0};
      vecs[15] = '{1'b1, REG_CTRL, 32'h5,         32'h0,         1'b0};
      vecs[16] = '{1'b1, REG_LEN,  32'h0,         32'h0,         1'b0};
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wen) cfgWrite(vecs[i].addr, vecs[i].wdata);
         cfgRead(vecs[i].addr, rd);
         chk($sformatf("vec%0d.rd", i), rd, vecs[i].expRd);
         chk($sformatf("vec%0d.irq", i), 32'(IRQ), 32'(vecs[i].expIrq));
         chk($sformatf("vec%0d.req", i), 32'(PrReq), 32'h0);
      end

      // basic copy of timer0 window into timer1
      mem[8'hC0] = 32'h9;  mem[8'hC1] = 32'h64;  mem[8'hC2] = 32'h0;
      expMem[8'hC0] = 32'h9; expMem[8'hC1] = 32'h64; expMem[8'hC2] = 32'h0;
      runCopy(32'h7F00, 32'h7F10, 3, 0, 1'b0, -1, -1);
      chk("timer1.reg0", mem[8'hC4], 32'h9);
      chk("timer1.reg1", mem[8'hC5], 32'h64);
      chk("timer1.reg2", mem[8'hC6], 32'h0);

      // IRQ path, then DONE_CLR drops it on the next cycle
      runCopy(32'h40, 32'h60, 1, 0, 1'b1, -1, -1);
      cfgWrite(REG_CTRL, 32'hA);
      chk("irqCleared", 32'(IRQ), 32'h0);

      // grant stalls, busy SRC write, aborts, wrap
      runCopy(32'h100, 32'h200, 2, 1, 1'b0, -1, -1);
      runCopy(32'h300, 32'h380, 4, 0, 1'b0, -1, 2);
      runCopy(32'h140, 32'h180, 4, 0, 1'b0, 4, -1);
      runCopy(32'h150, 32'h190, 4, 0, 1'b1, 3, -1);
      runCopy(32'hFFFF_FFFC, 32'h500, 2, 0, 1'b0, -1, -1);
      if (txQ.size() > 2) chk("wrapAddr", txQ[2].addr, 32'h0);
      else chk("wrapBeats", 32'(txQ.size()), 32'h4);

      for (int r = 0; r < 8; r++)
         runCopy($urandom, $urandom, int'($urandom_range(1, 8)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), -1, -1);

      // asynchronous reset during READ
      cfgWrite(REG_LEN, 32'h0);
      cfgWrite(REG_CTRL, 32'h3);
      cfgWrite(REG_SRC, 32'h7F00);
      cfgWrite(REG_LEN, 32'h4);
      Gnt = 1'b1;
      cfgWrite(REG_CTRL, 32'h3);
      CfgAddr = REG_CTRL;
      #1;
      chk("preRstReq", 32'({PrReq, IRQ}), 32'h3);
      chk("preRstAddr", PrAddr, 32'h7F00);
      Rst = 1'b0;
      #1;
      chk("rstAsyncCtl", 32'({PrReq, PrMask, PrWrite, IRQ}), 32'h0);
      chk("rstAsyncAddr", PrAddr, 32'h0);
      chk("rstAsyncData", PrWData, 32'h0);
      chk("rstAsyncCtrl", CfgRData, 32'h0);
      Gnt = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      cfgRead(REG_SRC, rd);
      chk("rstSrc", rd, 32'h0);
      cfgRead(REG_LEN, rd);
      chk("rstLen", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
